// File: rtl/ahb_pkg.sv
// Shared definitions for the AHB-Lite decoder/mux stage.
//   - HTRANS and HRESP encodings
//   - default slave region map (inclusive start/end per slave)
//   - slave count and the data-phase index reserved for the default slave
//   - default-slave FSM state type
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [31:0] S1_START_DEF = 32'h0000_0000;
    localparam logic [31:0] S1_END_DEF   = 32'h00FF_FFFF;
    localparam logic [31:0] S2_START_DEF = 32'h0100_0000;
    localparam logic [31:0] S2_END_DEF   = 32'h01FF_FFFF;
    localparam logic [31:0] S3_START_DEF = 32'h0200_0000;
    localparam logic [31:0] S3_END_DEF   = 32'h02FF_FFFF;
    localparam logic [31:0] S4_START_DEF = 32'h0300_0000;
    localparam logic [31:0] S4_END_DEF   = 32'h03FF_FFFF;

    localparam int unsigned NUM_SLAVES = 4;
    localparam logic [2:0]  DFLT_IDX   = 3'd4;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // True for transfer types that require a slave response (NONSEQ/SEQ).
    function automatic logic trans_active(input logic [1:0] htrans);
        logic act;
        unique case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: act = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            default: act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_decoder_mux_if.sv
// Bus bundle between the master/slaves and the decoder/mux stage.
//   HADDR, HTRANS        : master address phase
//   HSEL                 : one-hot slave select (address phase)
//   HRDATA_S, HREADYOUT_S, HRESP_S : per-slave data-phase responses, slave i at slice i
//   HRDATA, HREADY, HRESP: muxed response to the master (HREADY also goes to all slaves)
// Modport 'slave' is the interconnect view; 'master' is the view of the surrounding bus
// agents (master plus slaves) that drive requests and responses into it.
interface ahb_decoder_mux_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0]   HADDR;
    logic [1:0]          HTRANS;
    logic [3:0]          HSEL;
    logic [4*DATA_W-1:0] HRDATA_S;
    logic [3:0]          HREADYOUT_S;
    logic [3:0]          HRESP_S;
    logic [DATA_W-1:0]   HRDATA;
    logic                HREADY;
    logic                HRESP;

    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HSEL, HRDATA, HREADY, HRESP
    );

    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HSEL, HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_default_slave.sv
// Built-in default slave for unmapped addresses: answers NONSEQ/SEQ with the two-cycle
// AHB ERROR response and IDLE/BUSY with a zero-wait OKAY. Outputs are registered.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   HSEL          : address phase decodes to no mapped slave
//   HREADY        : bus-level ready (transfer acceptance)
//   HTRANS        : address-phase transfer type
//   HREADYOUT     : default-slave ready
//   HRESP         : default-slave response
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HSEL,
    input  logic       HREADY,
    input  logic [1:0] HTRANS,
    output logic       HREADYOUT,
    output logic       HRESP
);

    ds_state_e state;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
        end else begin
            unique case (state)
                // ERR2 completes the previous error and can accept a new one in the same cycle.
                DS_IDLE, DS_ERR2: begin
                    if (HREADY && HSEL && trans_active(HTRANS)) begin
                        state     <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= HRESP_ERROR;
                    end else begin
                        state     <= DS_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state     <= DS_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_ERROR;
                end
                default: begin
                    state     <= DS_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite decoder and response multiplexer for one master and four slaves.
// Decodes HADDR to a one-hot HSEL, registers the selection for the data phase and
// returns the selected slave's HRDATA/HREADYOUT/HRESP; unmapped addresses are served
// by the built-in default slave.
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   bus           : bus bundle (slave modport), see ahb_decoder_mux_if
module ahb_decoder_mux
    import ahb_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] S1_START = S1_START_DEF,
    parameter logic [ADDR_W-1:0] S1_END   = S1_END_DEF,
    parameter logic [ADDR_W-1:0] S2_START = S2_START_DEF,
    parameter logic [ADDR_W-1:0] S2_END   = S2_END_DEF,
    parameter logic [ADDR_W-1:0] S3_START = S3_START_DEF,
    parameter logic [ADDR_W-1:0] S3_END   = S3_END_DEF,
    parameter logic [ADDR_W-1:0] S4_START = S4_START_DEF,
    parameter logic [ADDR_W-1:0] S4_END   = S4_END_DEF
) (
    input logic               HCLK,
    input logic               HRESETn,
    ahb_decoder_mux_if.slave  bus
);

    localparam logic [ADDR_W-1:0] REG_START [NUM_SLAVES] = '{S1_START, S2_START, S3_START,
                                                             S4_START};
    localparam logic [ADDR_W-1:0] REG_END   [NUM_SLAVES] = '{S1_END, S2_END, S3_END, S4_END};

    logic [NUM_SLAVES-1:0] hsel;
    logic [2:0]            dec_idx;
    logic                  dflt_sel;
    logic [2:0]            dp_sel;
    logic                  ds_ready;
    logic                  ds_resp;

    // Inclusive range test as one unsigned compare: addr - start wraps above the span
    // when addr < start, so no separate lower-bound check is needed.
    always_comb begin
        hsel    = '0;
        dec_idx = DFLT_IDX;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if ((bus.HADDR - REG_START[i]) <= (REG_END[i] - REG_START[i])) begin
                hsel[i] = 1'b1;
                dec_idx = 3'(i);
            end
        end
    end

    assign dflt_sel = (dec_idx == DFLT_IDX);
    assign bus.HSEL = hsel;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_sel <= DFLT_IDX;
        end else if (bus.HREADY) begin
            dp_sel <= dec_idx;
        end
    end

    ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (dflt_sel),
        .HREADY    (bus.HREADY),
        .HTRANS    (bus.HTRANS),
        .HREADYOUT (ds_ready),
        .HRESP     (ds_resp)
    );

    // Default slave drives the response unless dp_sel names a mapped slave.
    always_comb begin
        bus.HRDATA = '0;
        bus.HREADY = ds_ready;
        bus.HRESP  = ds_resp;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dp_sel == 3'(i)) begin
                bus.HRDATA = bus.HRDATA_S[i*DATA_W +: DATA_W];
                bus.HREADY = bus.HREADYOUT_S[i];
                bus.HRESP  = bus.HRESP_S[i];
            end
        end
    end

endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux: decode vector table, hand-written multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_ahb_decoder_mux;
    import ahb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_decoder_mux_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_decoder_mux #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the data phase (0..3 slave, 4 default) and how many
    // error-response cycles remain (2 = first cycle, 1 = second, 0 = none).
    int   m_owner = 4;
    int   m_err   = 0;
    logic m_acc   = 1'b1;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [3:0]  hsel;
    } dec_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        if (a < 32'h0400_0000) return int'(a >> 24);
        return 4;
    endfunction

    task automatic model_check();
        int          d;
        logic [3:0]  e_hsel;
        logic        e_ready;
        logic        e_resp;
        logic [31:0] e_data;
        d      = model_decode(bus.HADDR);
        e_hsel = (d < 4) ? (4'b0001 << d) : 4'b0000;
        if (m_owner < 4) begin
            e_ready = bus.HREADYOUT_S[m_owner];
            e_resp  = bus.HRESP_S[m_owner];
            e_data  = bus.HRDATA_S[m_owner*32 +: 32];
        end else begin
            e_ready = (m_err != 2);
            e_resp  = (m_err != 0);
            e_data  = 32'h0;
        end
        chk("model_hsel", {28'h0, bus.HSEL}, {28'h0, e_hsel});
        chk("model_hready", {31'h0, bus.HREADY}, {31'h0, e_ready});
        chk("model_hresp", {31'h0, bus.HRESP}, {31'h0, e_resp});
        chk("model_hrdata", bus.HRDATA, e_data);
        m_acc = e_ready;
    endtask

    task automatic model_update();
        int d;
        int nerr;
        d    = model_decode(bus.HADDR);
        nerr = (m_err > 0) ? m_err - 1 : 0;
        if (m_acc) begin
            if (d == 4 && bus.HTRANS >= 2'd2) nerr = 2;
            m_owner = d;
        end
        m_err = nerr;
    endtask

    // One clock: model check on the falling edge, model update on the rising edge,
    // returns 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t);
        bus.HADDR  = a;
        bus.HTRANS = t;
    endtask

    // Called 1 unit after a rising edge; asserts and releases reset before the falling edge.
    task automatic rst_pulse(input string name);
        #2;
        rst_n = 1'b0;
        #1;
        chk({name, "_hready"}, {31'h0, bus.HREADY}, 32'h1);
        chk({name, "_hresp"}, {31'h0, bus.HRESP}, 32'h0);
        chk({name, "_hrdata"}, bus.HRDATA, 32'h0);
        m_owner = 4;
        m_err   = 0;
        m_acc   = 1'b1;
        rst_n   = 1'b1;
    endtask

    dec_vec_t vecs [12];

    initial begin
        vecs[0]  = '{32'h0000_0000, HTRANS_NONSEQ, 4'b0001};
        vecs[1]  = '{32'h00FF_FFFF, HTRANS_IDLE,   4'b0001};
        vecs[2]  = '{32'h0100_0000, HTRANS_SEQ,    4'b0010};
        vecs[3]  = '{32'h01FF_FFFF, HTRANS_BUSY,   4'b0010};
        vecs[4]  = '{32'h0200_0000, HTRANS_NONSEQ, 4'b0100};
        vecs[5]  = '{32'h02FF_FFFF, HTRANS_IDLE,   4'b0100};
        vecs[6]  = '{32'h0300_0000, HTRANS_NONSEQ, 4'b1000};
        vecs[7]  = '{32'h03FF_FFFF, HTRANS_SEQ,    4'b1000};
        vecs[8]  = '{32'h0400_0000, HTRANS_IDLE,   4'b0000};
        vecs[9]  = '{32'hFFFF_FFFF, HTRANS_BUSY,   4'b0000};
        vecs[10] = '{32'h0100_0010, HTRANS_IDLE,   4'b0010};
        vecs[11] = '{32'h0800_0000, HTRANS_NONSEQ, 4'b0000};

        bus.HADDR       = 32'h0;
        bus.HTRANS      = HTRANS_IDLE;
        bus.HRDATA_S    = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        bus.HREADYOUT_S = 4'b1111;
        bus.HRESP_S     = 4'b0000;

        // Power-on reset values.
        @(posedge clk);
        #1;
        chk("por_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("por_hresp", {31'h0, bus.HRESP}, 32'h0);
        chk("por_hrdata", bus.HRDATA, 32'h0);
        rst_n = 1'b1;

        // Decode table, including every region boundary.
        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].trans);
            #2;
            chk($sformatf("dec_hsel_%0d", i), {28'h0, bus.HSEL}, {28'h0, vecs[i].hsel});
            step();
        end
        drive(32'h0, HTRANS_IDLE);
        repeat (3) step();

        // NONSEQ read from slave 2.
        bus.HRDATA_S[63:32] = 32'hDEAD_BEEF;
        drive(32'h0100_0010, HTRANS_NONSEQ);
        #2;
        chk("s2_hsel", {28'h0, bus.HSEL}, 32'h2);
        step();
        drive(32'h0, HTRANS_IDLE);
        #2;
        chk("s2_hrdata", bus.HRDATA, 32'hDEAD_BEEF);
        chk("s2_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("s2_hresp", {31'h0, bus.HRESP}, 32'h0);
        step();

        // Asynchronous reset during a slave 2 data phase.
        drive(32'h0100_0010, HTRANS_NONSEQ);
        step();
        drive(32'h0, HTRANS_IDLE);
        rst_pulse("rst_s2");
        step();

        // Back-to-back: slave 1 with two wait states, then slave 3.
        drive(32'h00FF_FFFC, HTRANS_NONSEQ);
        step();
        drive(32'h0200_0000, HTRANS_NONSEQ);
        bus.HREADYOUT_S = 4'b1110;
        #2;
        chk("ws1_hready", {31'h0, bus.HREADY}, 32'h0);
        chk("ws1_hsel", {28'h0, bus.HSEL}, 32'h4);
        step();
        #2;
        chk("ws2_hready", {31'h0, bus.HREADY}, 32'h0);
        step();
        bus.HREADYOUT_S    = 4'b1111;
        bus.HRDATA_S[31:0] = 32'h1111_1111;
        #2;
        chk("ws_s1_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("ws_s1_hrdata", bus.HRDATA, 32'h1111_1111);
        step();
        drive(32'h0, HTRANS_IDLE);
        bus.HRDATA_S[95:64] = 32'h3333_3333;
        #2;
        chk("ws_s3_hrdata", bus.HRDATA, 32'h3333_3333);
        chk("ws_s3_hready", {31'h0, bus.HREADY}, 32'h1);
        step();

        // Unmapped NONSEQ: two-cycle error, then idle.
        drive(32'h0400_0000, HTRANS_NONSEQ);
        #2;
        chk("err_hsel", {28'h0, bus.HSEL}, 32'h0);
        step();
        drive(32'h0, HTRANS_IDLE);
        #2;
        chk("err1_hready", {31'h0, bus.HREADY}, 32'h0);
        chk("err1_hresp", {31'h0, bus.HRESP}, 32'h1);
        step();
        #2;
        chk("err2_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("err2_hresp", {31'h0, bus.HRESP}, 32'h1);
        step();
        #2;
        chk("err_done_hresp", {31'h0, bus.HRESP}, 32'h0);
        step();

        // Back-to-back unmapped NONSEQs, second issued in the ERR2 cycle.
        drive(32'h0500_0000, HTRANS_NONSEQ);
        step();
        drive(32'h0, HTRANS_IDLE);
        #2;
        chk("bb_err1a_hready", {31'h0, bus.HREADY}, 32'h0);
        step();
        drive(32'hFFFF_FFFF, HTRANS_NONSEQ);
        #2;
        chk("bb_err2a_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("bb_err2a_hresp", {31'h0, bus.HRESP}, 32'h1);
        step();
        drive(32'h0, HTRANS_IDLE);
        #2;
        chk("bb_err1b_hready", {31'h0, bus.HREADY}, 32'h0);
        chk("bb_err1b_hresp", {31'h0, bus.HRESP}, 32'h1);
        step();
        #2;
        chk("bb_err2b_hresp", {31'h0, bus.HRESP}, 32'h1);
        step();
        #2;
        chk("bb_idle_hresp", {31'h0, bus.HRESP}, 32'h0);
        step();

        // IDLE to an unmapped address: zero-wait OKAY.
        drive(32'h0800_0000, HTRANS_IDLE);
        step();
        drive(32'h0, HTRANS_IDLE);
        #2;
        chk("idle_unm_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("idle_unm_hresp", {31'h0, bus.HRESP}, 32'h0);
        step();

        // Reset during ERR1: no error cycle follows.
        drive(32'h0400_0000, HTRANS_NONSEQ);
        step();
        drive(32'h0, HTRANS_IDLE);
        rst_pulse("rst_err1");
        step();
        #2;
        chk("rst_err1_after_hready", {31'h0, bus.HREADY}, 32'h1);
        chk("rst_err1_after_hresp", {31'h0, bus.HRESP}, 32'h0);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int          k;
            k = $urandom_range(0, 5);
            if (k < 4) begin
                a = {8'(k), 24'($urandom)};
            end else if (k == 4) begin
                a = $urandom;
                if (a < 32'h0400_0000) a = a + 32'h0400_0000;
            end else begin
                a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h03FF_FFFF;
            end
            drive(a, 2'($urandom_range(0, 3)));
            for (int s = 0; s < 4; s++) begin
                bus.HREADYOUT_S[s] = ($urandom_range(0, 3) != 0);
                bus.HRESP_S[s]     = ($urandom_range(0, 7) == 0);
                bus.HRDATA_S[s*32 +: 32] = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
